hilo_unit: RTL and testbench
============================

# hilo_unit

HI/LO register file and multiply/divide sequencer for the MIPS54 core. It sits between the EX stage and the iterative unsigned divider core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and converts signed divides to magnitudes before starting the divider. It applies the sign fix-up on the divider's results, writes HI/LO, and stalls the pipeline while a divide is in flight.

## Interface
- No parameters; all datapaths are 32 bits.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- op_valid  in  1  operation present this cycle.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored, no state change).
- rs_data  in  32  operand A / dividend / MTHI-MTLO source.
- rt_data  in  32  operand B / divisor.
- stall  out  1  high while state is WAIT; upstream must hold op_valid/op/operands while high.
- hi  out  32  HI register (registered).
- lo  out  32  LO register (registered).
- div_start  out  1  one-cycle start pulse to divider core.
- div_dividend  out  32  unsigned dividend to core, valid while div_start high.
- div_divisor  out  32  unsigned divisor to core, valid while div_start high.
- div_q  in  32  core quotient, valid while div_done high.
- div_r  in  32  core remainder, valid while div_done high.
- div_done  in  1  one-cycle completion pulse from core.

## Operation
- States: IDLE, WAIT. Reset -> IDLE with hi = lo = 0, stall = 0, div_start = 0, sign flags 0.
- An operation is accepted only when op_valid = 1 and state = IDLE. Operations presented in WAIT are ignored.
- MULT: {hi,lo} <= signed(rs) * signed(rt), full 64-bit result, at the accepting edge. MULTU: same, unsigned. No stall.
- MTHI: hi <= rs. MTLO: lo <= rs. The other register is unchanged.
- DIV/DIVU with rt = 0: hi <= rs, lo <= 32'hFFFFFFFF at the accepting edge. The core is not started, div_start stays 0, and there is no stall.
- DIVU, rt != 0:
  - div_start = 1 combinationally in the accepting cycle.
  - div_dividend = rs, div_divisor = rt.
  - Sign flags q_neg = r_neg = 0. State -> WAIT.
- DIV, rt != 0:
  - div_dividend = |rs|, div_divisor = |rt| (two's-complement negate when bit 31 set; |0x80000000| = 0x80000000).
  - Latch q_neg = rs[31]^rt[31] and r_neg = rs[31]. State -> WAIT.
- WAIT: on a div_done cycle:
  - lo <= q_neg ? -div_q : div_q.
  - hi <= r_neg ? -div_r : div_r.
  - State -> IDLE at the same edge.
- div_done seen in IDLE is ignored.
- Signed overflow 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0 with no special case.
- Remainder sign follows the dividend and quotient truncates toward zero (MIPS semantics).

## Timing
- MULT/MULTU/MTHI/MTLO/zero-divisor: hi/lo are updated at the edge ending the accepting cycle and are visible the next cycle.
- Divide: div_start is high only in the accepting cycle.
  - stall goes high the cycle after acceptance and falls in the cycle after div_done.
  - hi/lo are updated at the same edge at which stall falls.
  - With the 32-iteration core, done arrives 33 cycles after start is sampled. stall is therefore high for 33 cycles and results are visible 34 cycles after the accepting cycle.
- A new operation is accepted in the cycle stall falls. Back-to-back divides therefore have no idle gap beyond that.
- Reset has priority over every other event, including a coincident div_done or a new op.
  - Reset during WAIT: state -> IDLE, hi = lo = 0, and any in-flight result is discarded.
  - The divider core shares reset and is cleared in the same edge.
- hi/lo outputs never change during WAIT.

## Test plan
- Reset, then MULT rs = 0xFFFFFFFE (-2), rt = 3 -> next cycle hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, stall never high. MULTU with the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
- DIVU rs = 100, rt = 7:
  - div_start pulses once with 100/7.
  - stall high 33 cycles.
  - Then lo = 14, hi = 2.
- DIV sign matrix with rs = ±7, rt = ±2:
  - (7,-2) -> lo = -3, hi = 1.
  - (-7,2) -> lo = -3, hi = -1.
  - (-7,-2) -> lo = 3, hi = -1.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV rs = 5, rt = 0 -> no div_start, no stall, next cycle hi = 5, lo = 0xFFFFFFFF. Then MTHI 0x1234 / MTLO 0x5678 -> hi = 0x1234, lo = 0x5678.
- During WAIT, present MTLO 0xAAAA held under stall:
  - lo is unchanged until the divide completes.
  - The divide results are written first.
  - MTLO is accepted in the cycle stall falls, giving lo = 0xAAAA one cycle later.
- Assert reset 10 cycles into a divide -> stall = 0, hi = lo = 0 the next cycle. A late div_done pulse is ignored and a fresh DIVU 9/3 gives lo = 3, hi = 0.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register file and multiply/divide sequencer for the MIPS54 EX stage.
// Multiplies and moves complete in one cycle; divides hand magnitudes to an external unsigned core.
module hilo_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_done
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;

    logic               accept;
    logic               is_div;
    logic               rt_zero;
    logic signed [63:0] rs_s;
    logic signed [63:0] rt_s;
    logic signed [63:0] mul_s;
    logic [63:0]        mul_u;

    // Two's-complement magnitude; 0x80000000 maps to itself.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    assign accept  = op_valid && (state_q == IDLE);
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign rt_zero = (rt_data == 32'd0);

    assign rs_s  = $signed({{32{rs_data[31]}}, rs_data});
    assign rt_s  = $signed({{32{rt_data[31]}}, rt_data});
    assign mul_s = rs_s * rt_s;
    assign mul_u = {32'd0, rs_data} * {32'd0, rt_data};

    assign div_start    = accept && is_div && !rt_zero;
    assign div_dividend = (op == OP_DIV) ? abs32(rs_data) : rs_data;
    assign div_divisor  = (op == OP_DIV) ? abs32(rt_data) : rt_data;

    assign stall = (state_q == WAIT);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (state_q == IDLE) begin
            if (op_valid) begin
                case (op)
                    OP_MULT:  {hi_d, lo_d} = mul_s;
                    OP_MULTU: {hi_d, lo_d} = mul_u;
                    OP_MTHI:  hi_d = rs_data;
                    OP_MTLO:  lo_d = rs_data;
                    OP_DIV, OP_DIVU: begin
                        if (rt_zero) begin
                            hi_d = rs_data;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            state_d = WAIT;
                            q_neg_d = (op == OP_DIV) && (rs_data[31] ^ rt_data[31]);
                            r_neg_d = (op == OP_DIV) && rs_data[31];
                        end
                    end
                    default: ;
                endcase
            end
        end else if (div_done) begin
            // Remainder takes the dividend's sign; quotient truncates toward zero.
            lo_d    = neg_if(div_q, q_neg_q);
            hi_d    = neg_if(div_r, r_neg_q);
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed steps plus random ops against an arithmetic HI/LO model,
// with a behavioural 33-cycle divider core attached.
module tb_hilo_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [31:0] hi, lo;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor;
    logic [31:0] div_q, div_r;
    logic        div_done;

    logic        core_busy, core_done, man_done;
    int          core_cnt;
    logic [31:0] lat_a, lat_b, core_q, core_r;

    int          checks = 0;
    int          failures = 0;
    int          start_cnt = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clock = ~clock;

    hilo_unit dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .hi(hi), .lo(lo),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_q(div_q), .div_r(div_r), .div_done(div_done)
    );

    // Unsigned divider core: done is high in the 33rd cycle after start is sampled.
    always @(posedge clock) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_done <= 1'b0;
            core_cnt  <= 0;
        end else begin
            core_done <= 1'b0;
            if (core_busy) begin
                if (core_cnt == 32) begin
                    core_done <= 1'b1;
                    core_busy <= 1'b0;
                    core_q    <= (lat_b != 0) ? lat_a / lat_b : 32'd0;
                    core_r    <= (lat_b != 0) ? lat_a % lat_b : 32'd0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
            if (div_start) begin
                core_busy <= 1'b1;
                core_cnt  <= 1;
                lat_a     <= div_dividend;
                lat_b     <= div_divisor;
            end
        end
    end

    always @(posedge clock) if (div_start) start_cnt <= start_cnt + 1;

    assign div_done = core_done | man_done;
    assign div_q    = core_q;
    assign div_r    = core_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (o)
            3'd0: {m_hi, m_lo} = sa * sb;
            3'd1: {m_hi, m_lo} = ua * ub;
            3'd2, 3'd3: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          n, s0;
        bit          exp_start, moved;
        logic        started;
        logic [31:0] dd, dv, h0, l0;
        longint      sa, sb;
        s0 = start_cnt;
        exp_start = ((o == 3'd2) || (o == 3'd3)) && (b != 0);
        @(negedge clock);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        #1;
        started = div_start; dd = div_dividend; dv = div_divisor;
        h0 = hi; l0 = lo;
        chk({tag, ".start"}, {31'd0, started}, {31'd0, exp_start});
        if (exp_start) begin
            sa = $signed(a);
            sb = $signed(b);
            chk({tag, ".dividend"}, dd, (o == 3'd2) ? 32'(sa < 0 ? -sa : sa) : a);
            chk({tag, ".divisor"},  dv, (o == 3'd2) ? 32'(sb < 0 ? -sb : sb) : b);
        end
        model(o, a, b);
        @(negedge clock);
        op_valid = 1'b0;
        n = 0;
        moved = 1'b0;
        while (stall === 1'b1 && n < 100) begin
            if (hi !== h0 || lo !== l0) moved = 1'b1;
            n++;
            @(negedge clock);
        end
        chk({tag, ".stall_cycles"}, 32'(n), exp_start ? 32'd33 : 32'd0);
        chk({tag, ".start_pulses"}, 32'(start_cnt - s0), exp_start ? 32'd1 : 32'd0);
        if (exp_start) chk({tag, ".hold_in_wait"}, {31'd0, moved}, 32'd0);
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [4];
        sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000;
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
    endfunction

    initial begin
        int n;
        bit bad;
        logic [31:0] prior_lo;
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs_data = 0; rt_data = 0; man_done = 1'b0;
        m_hi = 0; m_lo = 0;
        repeat (3) @(negedge clock);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.div_start", {31'd0, div_start}, 32'd0);
        reset = 1'b0;

        do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult.hi_const", hi, 32'hFFFF_FFFF);
        chk("mult.lo_const", lo, 32'hFFFF_FFFA);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu.hi_const", hi, 32'h0000_0002);
        do_op("divu_100_7", 3'd3, 32'd100, 32'd7);
        chk("divu.lo_const", lo, 32'd14);
        chk("divu.hi_const", hi, 32'd2);
        do_op("div_7_m2", 3'd2, 32'd7, -32'sd2);
        do_op("div_m7_2", 3'd2, -32'sd7, 32'd2);
        do_op("div_m7_m2", 3'd2, -32'sd7, -32'sd2);
        chk("div_m7_m2.hi_const", hi, 32'hFFFF_FFFF);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lo_const", lo, 32'h8000_0000);
        do_op("div_by0", 3'd2, 32'd5, 32'd0);
        do_op("mthi", 3'd4, 32'h1234, 32'd9);
        do_op("mtlo", 3'd5, 32'h5678, 32'd9);
        do_op("reserved6", 3'd6, 32'hDEAD, 32'd1);
        do_op("reserved7", 3'd7, 32'hBEEF, 32'd2);

        // MTLO held under stall must wait for the divide to write back first.
        prior_lo = lo;
        @(negedge clock);
        op_valid = 1'b1; op = 3'd3; rs_data = 32'd50; rt_data = 32'd5;
        @(negedge clock);
        op = 3'd5; rs_data = 32'hAAAA; rt_data = 32'd0;
        n = 0; bad = 1'b0;
        while (stall === 1'b1 && n < 100) begin
            if (lo !== prior_lo) bad = 1'b1;
            n++;
            @(negedge clock);
        end
        chk("held.stall_cycles", 32'(n), 32'd33);
        chk("held.lo_frozen", {31'd0, bad}, 32'd0);
        chk("held.div_lo", lo, 32'd10);
        chk("held.div_hi", hi, 32'd0);
        @(negedge clock);
        op_valid = 1'b0;
        chk("held.mtlo", lo, 32'hAAAA);
        chk("held.stall_after", {31'd0, stall}, 32'd0);
        m_hi = 32'd0; m_lo = 32'hAAAA;

        // Reset ten cycles into a divide discards it.
        @(negedge clock);
        op_valid = 1'b1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (9) @(negedge clock);
        chk("rstwait.stall_before", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstwait.stall", {31'd0, stall}, 32'd0);
        chk("rstwait.hi", hi, 32'd0);
        chk("rstwait.lo", lo, 32'd0);
        m_hi = 0; m_lo = 0;
        man_done = 1'b1;
        @(negedge clock);
        man_done = 1'b0;
        chk("late_done.hi", hi, 32'd0);
        chk("late_done.lo", lo, 32'd0);
        chk("late_done.stall", {31'd0, stall}, 32'd0);
        do_op("divu_9_3", 3'd3, 32'd9, 32'd3);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 6));
            a = pick();
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
            do_op($sformatf("rnd%0d_op%0d", i, o), o, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
